// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared constants and types for the I2C-to-UART bridge
// Contents: register offsets, STATUS/CTRL bit positions, UART FSM state type.
package uart_bridge_pkg;

    localparam logic [3:0] REG_DATA    = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h1;
    localparam logic [3:0] REG_BAUD_LO = 4'h2;
    localparam logic [3:0] REG_BAUD_HI = 4'h3;
    localparam logic [3:0] REG_CTRL    = 4'h4;

    localparam int STAT_BUSY  = 7;
    localparam int STAT_FULL  = 6;
    localparam int STAT_EMPTY = 5;
    localparam int STAT_OVF   = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_FLUSH   = 2;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

endpackage

// File: rtl/sync_fifo_byte.sv
// rtl/sync_fifo_byte.sv - byte-wide synchronous FIFO with flush
// Ports: clk, rst_n (sync, active-low); push_i/din_i write side; pop_i/dout_o
// read side (dout_o shows the head while not empty); flush_i empties the FIFO
// and wins over push/pop; full_o, empty_o, count_o report occupancy.
module sync_fifo_byte #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/i2c_uart_bridge.sv
// rtl/i2c_uart_bridge.sv - register-mapped TX FIFO feeding an 8N1 UART transmitter
// Ports: clk, rst_n (sync, active-low); addr/wen/wdata bus writes;
// rdata_used acknowledges a read; rdata/sel combinational read path;
// tx serial line (idle high); tx_busy high while a frame is on the wire.
module i2c_uart_bridge
    import uart_bridge_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h10,
    parameter int          DEPTH      = 8,
    parameter logic [15:0] BAUD_RESET = 16'd433
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic       wen,
    input  logic [7:0] wdata,
    input  logic       rdata_used,
    output logic [7:0] rdata,
    output logic       sel,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    offset;
    logic          wr;
    logic          wr_data;
    logic          wr_ctrl;
    logic          flush;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;
    logic          overflow_d;

    logic          enable_q;
    logic          overflow_q;
    logic [15:0]   div_q;

    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    uart_state_e   state_q;
    logic [15:0]   timer_q;
    logic [15:0]   div_lat_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;

    logic [7:0]    status;

    assign offset  = addr[3:0];
    assign sel     = (addr[7:4] == BASE_ADDR[7:4]);
    assign wr      = wen && sel;
    assign wr_data = wr && (offset == REG_DATA);
    assign wr_ctrl = wr && (offset == REG_CTRL);
    assign flush   = wr_ctrl && wdata[CTRL_FLUSH];

    // The FSM only leaves IDLE on a real pop; a same-cycle flush cancels it.
    assign pop     = (state_q == UART_IDLE) && enable_q && !fifo_empty && !flush;

    assign ovf_set    = wr_data && fifo_full && !pop;
    assign ovf_clr    = (wr_ctrl && wdata[CTRL_CLR_OVF]) ||
                        (rdata_used && sel && (offset == REG_STATUS));
    assign overflow_d = ovf_set || (overflow_q && !ovf_clr);

    sync_fifo_byte #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_data),
        .din_i   (wdata),
        .pop_i   (pop),
        .flush_i (flush),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            div_q      <= BAUD_RESET;
        end else begin
            overflow_q <= overflow_d;
            if (wr && (offset == REG_BAUD_LO)) begin
                div_q[7:0] <= wdata;
            end
            if (wr && (offset == REG_BAUD_HI)) begin
                div_q[15:8] <= wdata;
            end
            if (wr_ctrl) begin
                enable_q <= wdata[CTRL_EN];
            end
        end
    end

    // tx/tx_busy are registered from the current state, so the line trails the
    // state by one clock; each phase still lasts exactly divider+1 clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= UART_IDLE;
            timer_q   <= '0;
            div_lat_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_q != UART_IDLE);
            case (state_q)
                UART_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= fifo_dout;
                        timer_q   <= div_q;
                        div_lat_q <= div_q;
                        bit_cnt_q <= '0;
                        state_q   <= UART_START;
                    end
                end
                UART_START: begin
                    tx_q <= 1'b0;
                    if (timer_q == '0) begin
                        timer_q <= div_lat_q;
                        state_q <= UART_DATA;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                UART_DATA: begin
                    tx_q <= shift_q[0];
                    if (timer_q == '0) begin
                        timer_q   <= div_lat_q;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= UART_STOP;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                UART_STOP: begin
                    tx_q <= 1'b1;
                    if (timer_q == '0) begin
                        state_q <= UART_IDLE;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: state_q <= UART_IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

    always_comb begin
        status             = '0;
        status[STAT_BUSY]  = busy_q;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_OVF]   = overflow_q;
        status[3:0]        = 4'(fifo_count);
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                REG_STATUS:  rdata = status;
                REG_BAUD_LO: rdata = div_q[7:0];
                REG_BAUD_HI: rdata = div_q[15:8];
                REG_CTRL:    rdata = {7'b0, enable_q};
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_uart_bridge.sv
// tb/tb_i2c_uart_bridge.sv - self-checking bench for i2c_uart_bridge
module tb_i2c_uart_bridge;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       wen = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rdata_used = 1'b0;
    logic [7:0] rdata;
    logic       sel;
    logic       tx;
    logic       tx_busy;

    int tests = 0;
    int fails = 0;

    i2c_uart_bridge #(
        .BASE_ADDR  (8'h10),
        .DEPTH      (DEPTH),
        .BAUD_RESET (16'd433)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .wen        (wen),
        .wdata      (wdata),
        .rdata_used (rdata_used),
        .rdata      (rdata),
        .sel        (sel),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: FIFO as a queue, each frame as a 10-symbol timeline.
    logic [7:0] mq[$];
    bit         m_ovf = 0;
    bit         m_en = 0;
    int         m_div = 433;
    int         ecnt = 0;
    int         fp = 0;
    int         fdv = 0;
    int         free_edge = 0;
    bit         fv = 0;
    logic [9:0] fbits = '0;
    bit         exp_tx = 1;
    bit         exp_busy = 0;
    bit         chk_on = 0;

    always @(posedge clk) begin : model_p
        logic       msel_m;
        logic [3:0] off_m;
        logic [7:0] head_m;
        bit         wr_m, fl_m, push_m, pop_m, full_m, set_m, clr_m;
        ecnt++;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0;
            m_en = 0;
            m_div = 433;
            fv = 0;
            free_edge = 0;
            chk_on = 1;
        end else begin
            msel_m = (addr[7:4] == 4'h1);
            off_m  = addr[3:0];
            wr_m   = wen && msel_m;
            fl_m   = wr_m && off_m == 4'h4 && wdata[2];
            push_m = wr_m && off_m == 4'h0;
            full_m = (mq.size() == DEPTH);
            pop_m  = (ecnt >= free_edge) && m_en && mq.size() > 0 && !fl_m;
            set_m  = push_m && full_m && !pop_m;
            clr_m  = (wr_m && off_m == 4'h4 && wdata[1]) || (rdata_used && msel_m && off_m == 4'h1);
            if (pop_m) begin
                head_m = mq.pop_front();
                fbits = {1'b1, head_m, 1'b0};
                fp = ecnt;
                fdv = m_div;
                fv = 1;
                free_edge = ecnt + 10 * (fdv + 1) + 1;
            end
            if (fl_m) mq.delete();
            else if (push_m && !set_m) mq.push_back(wdata);
            if (set_m) m_ovf = 1;
            else if (clr_m) m_ovf = 0;
            if (wr_m && off_m == 4'h2) m_div = (m_div & 32'hFF00) | int'(wdata);
            if (wr_m && off_m == 4'h3) m_div = (m_div & 32'h00FF) | (int'(wdata) << 8);
            if (wr_m && off_m == 4'h4) m_en = wdata[0];
        end
        if (fv && ecnt >= fp + 1 && ecnt <= fp + 10 * (fdv + 1)) begin
            exp_busy = 1;
            exp_tx = fbits[(ecnt - fp - 1) / (fdv + 1)];
        end else begin
            exp_busy = 0;
            exp_tx = 1;
        end
    end

    function automatic logic [7:0] exp_rdata(input logic [7:0] a);
        int n;
        n = mq.size();
        if (a[7:4] != 4'h1) return 8'h00;
        case (a[3:0])
            4'h1:    return {exp_busy, n == DEPTH, n == 0, m_ovf, 4'(n)};
            4'h2:    return 8'(m_div);
            4'h3:    return 8'(m_div >> 8);
            4'h4:    return {7'b0, m_en};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            check("cyc_tx", 16'(tx), 16'(exp_tx));
            check("cyc_busy", 16'(tx_busy), 16'(exp_busy));
            check("cyc_sel", 16'(sel), 16'(addr[7:4] == 4'h1));
            check("cyc_rdata", 16'(rdata), 16'(exp_rdata(addr)));
        end
    end

    // Line monitor: frame receiver plus busy/idle run lengths.
    int         rx_div = 3;
    logic [7:0] rxq[$];
    int         runs[$];
    int         gaps[$];
    bit         prev_busy = 0;
    bit         seen = 0;
    int         hi_run = 0;
    int         lo_run = 0;
    int         kpos = 0;
    logic [7:0] rsh = '0;

    always @(negedge clk) begin : mon_p
        int bp;
        if (tx_busy === 1'b1) begin
            if (!prev_busy) begin
                kpos = 0;
                if (seen) gaps.push_back(lo_run);
            end else begin
                kpos++;
            end
            hi_run++;
            if (kpos % (rx_div + 1) == rx_div / 2) begin
                bp = kpos / (rx_div + 1);
                if (bp >= 1 && bp <= 8) rsh[bp - 1] = tx;
                if (bp == 8) rxq.push_back(rsh);
            end
        end else begin
            if (prev_busy) begin
                runs.push_back(hi_run);
                hi_run = 0;
                seen = 1;
                lo_run = 0;
            end
            lo_run++;
        end
        prev_busy = tx_busy;
    end

    task automatic clear_mon(input int div);
        #2;
        rxq.delete();
        runs.delete();
        gaps.delete();
        seen = 0;
        hi_run = 0;
        lo_run = 0;
        rx_div = div;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a;
        wen = 1'b1;
        wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [7:0] a, input logic [7:0] e);
        addr = a;
        #1;
        check(n, 16'(rdata), 16'(e));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [44:0] s_tx;
        logic [9:0]  fv_bits;
        int          first_low;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        rd_chk("reset_status", 8'h11, 8'h20);
        rd_chk("reset_baud_lo", 8'h12, 8'hB1);
        rd_chk("reset_baud_hi", 8'h13, 8'h01);
        rd_chk("reset_ctrl", 8'h14, 8'h00);
        check("reset_tx", 16'(tx), 16'h1);

        // Single frame 0xA5 at divider 3.
        clear_mon(3);
        wr(8'h12, 8'h03);
        wr(8'h13, 8'h00);
        wr(8'h14, 8'h01);
        wr(8'h10, 8'hA5);
        for (int i = 0; i < 45; i++) begin
            s_tx[i] = tx;
            @(negedge clk);
        end
        first_low = -1;
        for (int i = 44; i >= 0; i--) if (s_tx[i] == 1'b0) first_low = i;
        check("frame_latency", 16'(first_low), 16'd2);
        if (first_low < 0) first_low = 0;
        if (first_low > 7) first_low = 7;
        for (int j = 0; j < 10; j++) fv_bits[j] = s_tx[first_low + 4 * j + 1];
        check("frame_bits_a5", 16'(fv_bits), 16'h34A);
        repeat (5) @(negedge clk);
        check("frame_busy_runs", 16'(runs.size()), 16'd1);
        if (runs.size() > 0) check("frame_busy_len", 16'(runs[0]), 16'd40);
        rd_chk("frame_status_after", 8'h11, 8'h20);

        // Overflow with enable off, then drain.
        clear_mon(3);
        wr(8'h14, 8'h00);
        for (int i = 0; i < 9; i++) wr(8'h10, 8'h11 + 8'(i));
        rd_chk("ovf_status", 8'h11, 8'h58);
        addr = 8'h11;
        rdata_used = 1'b1;
        @(negedge clk);
        rdata_used = 1'b0;
        rd_chk("ovf_cleared", 8'h11, 8'h48);
        wr(8'h14, 8'h01);
        repeat (350) @(negedge clk);
        check("ovf_frames", 16'(rxq.size()), 16'd8);
        for (int i = 0; i < 8; i++)
            if (i < rxq.size()) check("ovf_rx_byte", 16'(rxq[i]), 16'(8'h11 + 8'(i)));
        rd_chk("ovf_status_drained", 8'h11, 8'h20);

        // Back-to-back at divider 0 with push during pop.
        clear_mon(0);
        wr(8'h12, 8'h00);
        wr(8'h10, 8'hC3);
        wr(8'h10, 8'h5A);
        wr(8'h10, 8'h0F);
        rd_chk("b2b_peak_status", 8'h11, 8'h82);
        repeat (40) @(negedge clk);
        check("b2b_frames", 16'(runs.size()), 16'd3);
        foreach (runs[i]) check("b2b_frame_len", 16'(runs[i]), 16'd10);
        check("b2b_gaps", 16'(gaps.size()), 16'd2);
        foreach (gaps[i]) check("b2b_gap_len", 16'(gaps[i]), 16'd1);
        check("b2b_rx_count", 16'(rxq.size()), 16'd3);
        if (rxq.size() == 3) begin
            check("b2b_rx0", 16'(rxq[0]), 16'h00C3);
            check("b2b_rx1", 16'(rxq[1]), 16'h005A);
            check("b2b_rx2", 16'(rxq[2]), 16'h000F);
        end

        // Flush during the first frame.
        clear_mon(3);
        wr(8'h12, 8'h03);
        wr(8'h10, 8'h31);
        wr(8'h10, 8'h32);
        wr(8'h10, 8'h33);
        repeat (10) @(negedge clk);
        wr(8'h14, 8'h05);
        repeat (60) @(negedge clk);
        check("flush_frames", 16'(runs.size()), 16'd1);
        check("flush_rx_count", 16'(rxq.size()), 16'd1);
        if (rxq.size() > 0) check("flush_rx0", 16'(rxq[0]), 16'h0031);
        rd_chk("flush_status", 8'h11, 8'h20);

        // Reset in the middle of a frame.
        wr(8'h10, 8'h77);
        repeat (8) @(negedge clk);
        check("pre_reset_busy", 16'(tx_busy), 16'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_tx", 16'(tx), 16'h1);
        check("rst_busy", 16'(tx_busy), 16'h0);
        rst_n = 1'b1;
        rd_chk("rst_baud_lo", 8'h12, 8'hB1);
        rd_chk("rst_baud_hi", 8'h13, 8'h01);

        // Address decode outside the window.
        clear_mon(3);
        addr = 8'h20;
        wen = 1'b1;
        wdata = 8'h5A;
        #1;
        check("dec_sel_20", 16'(sel), 16'h0);
        check("dec_rdata_20", 16'(rdata), 16'h0);
        @(negedge clk);
        addr = 8'h05;
        wdata = 8'hFF;
        #1;
        check("dec_sel_05", 16'(sel), 16'h0);
        check("dec_rdata_05", 16'(rdata), 16'h0);
        @(negedge clk);
        wr(8'h22, 8'h00);
        rd_chk("dec_baud_kept", 8'h12, 8'hB1);
        rd_chk("dec_status_kept", 8'h11, 8'h20);
        rd_chk("dec_ctrl_kept", 8'h14, 8'h00);
        addr = 8'h17;
        #1;
        check("dec_sel_17", 16'(sel), 16'h1);
        check("dec_rdata_17", 16'(rdata), 16'h0);
        @(negedge clk);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
